// File: rtl/depth_test_writer_if.sv
// ---------------------------------------------------------------------------
// Interfaces used by depth_test_writer.
//
// dtw_frag_if : rasterizer -> depth_test_writer fragment stream.
//   master (rasterizer)   drives  frag_addr, frag_color, frag_depth, frag_valid, done_in
//                         samples frag_stall, done_out
//   slave  (writer)       the mirror image
//
// dtw_mem_if  : depth_test_writer -> frame buffer (Avalon-MM style, pipelined reads).
//   master (writer)       drives  mem_address, mem_read, mem_write, mem_writedata
//                         samples mem_readdata, mem_readdatavalid, mem_waitrequest
//   slave  (memory)       the mirror image
// ---------------------------------------------------------------------------
interface dtw_frag_if #(
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0] frag_addr;
  logic [23:0]       frag_color;
  logic [31:0]       frag_depth;
  logic              frag_valid;
  logic              frag_stall;
  logic              done_in;
  logic              done_out;

  modport master (
    output frag_addr, frag_color, frag_depth, frag_valid, done_in,
    input  frag_stall, done_out
  );

  modport slave (
    input  frag_addr, frag_color, frag_depth, frag_valid, done_in,
    output frag_stall, done_out
  );
endinterface

interface dtw_mem_if #(
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic              mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_readdatavalid, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_readdatavalid, mem_waitrequest
  );
endinterface

// File: rtl/depth_test_writer.sv
// ---------------------------------------------------------------------------
// depth_test_writer
//
// Fragment sink behind the triangle rasterizer. Fragments (addr, colour,
// depth) are queued in a small FIFO. Each one is popped into working
// registers, its stored depth is read from the frame buffer, and colour and
// depth are written back when the fragment is strictly closer (signed Q16.16,
// smaller = closer). An end-of-frame done is forwarded once every accepted
// fragment has been committed.
//
// Pixel slot layout: addr+0 = colour word {8'h00, B, G, R}, addr+4 = depth.
//
// Build option: define DEPTH_TEST_EN to enable the read-compare-write path.
// Without it no reads are issued and every fragment is written.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-low
//   frag         dtw_frag_if.slave  : fragment stream, frag_stall back-pressure,
//                                     done_in / done_out (1-cycle pulse)
//   mem          dtw_mem_if.master  : frame buffer port, requests registered and
//                                     held stable while mem_waitrequest is high
//   frag_passed  fragments written (wraps at 2^32)
//   frag_killed  fragments rejected by the depth test (wraps at 2^32)
// ---------------------------------------------------------------------------
module depth_test_writer #(
  parameter int FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int ADDR_W     = 26
) (
  input  logic        clock,
  input  logic        reset,
  dtw_frag_if.slave   frag,
  dtw_mem_if.master   mem,
  output logic [31:0] frag_passed,
  output logic [31:0] frag_killed
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       color;
    logic [31:0]       depth;
  } frag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_COL,
    S_WR_DEP
  } state_t;

  // FIFO
  frag_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_full;
  logic [PTR_W:0]    w_count_next;
  logic              w_push;
  logic              w_pop;
  frag_t             w_frag_in;

  // FSM and working fragment
  state_t            r_state;
  state_t            w_state_next;
  frag_t             r_work;
  frag_t             w_work_next;
  logic              w_commit;
  logic              w_kill;

  // Registered memory requests and their next values
  logic [ADDR_W-1:0] r_mem_address;
  logic              r_mem_write;
  logic [31:0]       r_mem_writedata;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_addr_plus4;
  logic              w_write_next;
  logic [31:0]       w_wdata_next;
`ifdef DEPTH_TEST_EN
  logic              r_mem_read;
  logic              w_read_next;
`endif

  // Done tracking and counters
  logic              r_done_pend;
  logic              r_done_out;
  logic              w_done_fire;
  logic [31:0]       r_passed;
  logic [31:0]       r_killed;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  assign w_frag_in    = {frag.frag_addr, frag.frag_color, frag.frag_depth};
  assign w_push       = frag.frag_valid && !frag.frag_stall;
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
  assign w_count_next = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  // NOTE: the fragment store has no reset; occupancy is tracked by the
  // pointers and count, so stale entries are never observed and the array
  // can map onto plain RAM/flops without a reset network.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_frag_in;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (PTR_W+1)'(FIFO_DEPTH));
    end
  end

  // Held high while reset is asserted so nothing is accepted into a FIFO
  // that is being flushed; otherwise the registered full flag.
  assign frag.frag_stall = r_full || !reset;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_work  <= '0;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state, and next values of the registered memory requests.
  // Requests are a function of the *next* state so they appear on the bus
  // in the same cycle the FSM enters the request state.
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_commit     = 1'b0;
    w_kill       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_work_next = r_fifo[r_rd_ptr];
`ifdef DEPTH_TEST_EN
          w_state_next = S_RD_REQ;
`else
          w_state_next = S_WR_COL;
`endif
        end
      end
`ifdef DEPTH_TEST_EN
      S_RD_REQ: begin
        if (!mem.mem_waitrequest) w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem.mem_readdatavalid) begin
          // Equal depth fails: only strictly closer fragments are drawn.
          if ($signed(r_work.depth) < $signed(mem.mem_readdata)) begin
            w_state_next = S_WR_COL;
          end else begin
            w_state_next = S_IDLE;
            w_kill       = 1'b1;
          end
        end
      end
`endif
      S_WR_COL: begin
        if (!mem.mem_waitrequest) w_state_next = S_WR_DEP;
      end
      S_WR_DEP: begin
        if (!mem.mem_waitrequest) begin
          w_state_next = S_IDLE;
          w_commit     = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Wraps modulo 2^ADDR_W by width.
    w_addr_plus4 = w_work_next.addr + ADDR_W'(4);
    w_addr_next  = '0;
    w_wdata_next = '0;
    w_write_next = (w_state_next == S_WR_COL) || (w_state_next == S_WR_DEP);
`ifdef DEPTH_TEST_EN
    w_read_next  = (w_state_next == S_RD_REQ);
`endif
    case (w_state_next)
      S_RD_REQ: w_addr_next = w_addr_plus4;
      S_WR_COL: begin
        w_addr_next  = w_work_next.addr;
        w_wdata_next = {8'h00, w_work_next.color};
      end
      S_WR_DEP: begin
        w_addr_next  = w_addr_plus4;
        w_wdata_next = w_work_next.depth;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered bus outputs, done pulse and counters
  // -------------------------------------------------------------------------
  // done_out needs the pipeline fully drained: nothing queued, nothing in
  // flight, and no fragment being popped this cycle.
  assign w_done_fire = r_done_pend && (r_count == '0) && (r_state == S_IDLE) && !w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem_address   <= '0;
      r_mem_write     <= 1'b0;
      r_mem_writedata <= '0;
`ifdef DEPTH_TEST_EN
      r_mem_read      <= 1'b0;
`endif
      r_done_pend     <= 1'b0;
      r_done_out      <= 1'b0;
      r_passed        <= '0;
      r_killed        <= '0;
    end else begin
      r_mem_address   <= w_addr_next;
      r_mem_write     <= w_write_next;
      r_mem_writedata <= w_wdata_next;
`ifdef DEPTH_TEST_EN
      r_mem_read      <= w_read_next;
`endif
      // A done_in arriving on the firing edge is absorbed into this pulse.
      r_done_pend     <= w_done_fire ? 1'b0 : (r_done_pend || frag.done_in);
      r_done_out      <= w_done_fire;
      if (w_commit) r_passed <= r_passed + 32'd1;
      if (w_kill)   r_killed <= r_killed + 32'd1;
    end
  end

  assign mem.mem_address   = r_mem_address;
  assign mem.mem_write     = r_mem_write;
  assign mem.mem_writedata = r_mem_writedata;
`ifdef DEPTH_TEST_EN
  assign mem.mem_read      = r_mem_read;
`else
  assign mem.mem_read      = 1'b0;
`endif
  assign frag.done_out     = r_done_out;
  assign frag_passed       = r_passed;
  assign frag_killed       = r_killed;

endmodule

// File: tb/tb_depth_test_writer.sv
// ---------------------------------------------------------------------------
// Testbench for depth_test_writer. Directed fragments push their expected
// frame-buffer writes into a queue; a monitor on the falling edge pops and
// compares every accepted write, checks request stability under
// waitrequest, and checks done_out timing. Counters and reset values are
// checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_depth_test_writer;
  localparam int ADDR_W = 26;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] frag_passed;
  logic [31:0] frag_killed;

  always #5 clock = ~clock;

  dtw_frag_if #(.ADDR_W(ADDR_W)) fi ();
  dtw_mem_if  #(.ADDR_W(ADDR_W)) mi ();

  depth_test_writer #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .frag        (fi),
    .mem         (mi),
    .frag_passed (frag_passed),
    .frag_killed (frag_killed)
  );

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          last_wr_edge = -100;
  int          done_pulses  = 0;
  int          exp_passed   = 0;
  bit          exp_done     = 1'b0;
  bit          both_seen    = 1'b0;
  bit          hold_valid   = 1'b0;
  logic [90:0] hold_snap;
  wr_t         exp_q [$];
  logic [31:0] fb [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] rd_addr;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Frame-buffer read responder: data one cycle after the accepting edge.
  always begin
    @(posedge clock);
    if (reset && mi.mem_read && !mi.mem_waitrequest) begin
      rd_addr = mi.mem_address;
      #1;
      mi.mem_readdata      = fb.exists(rd_addr) ? fb[rd_addr] : 32'h7FFF_FFFF;
      mi.mem_readdatavalid = 1'b1;
      @(posedge clock);
      #1;
      mi.mem_readdatavalid = 1'b0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clock) begin
    wr_t e;
    if (!reset) begin
      hold_valid = 1'b0;
    end else begin
      if (mi.mem_read && mi.mem_write) both_seen = 1'b1;

      if (hold_valid)
        check({mi.mem_read, mi.mem_write, mi.mem_address, mi.mem_writedata} == hold_snap,
              "hold_stable", 64'(mi.mem_address), 64'(hold_snap[57:32]));
      hold_valid = (mi.mem_read || mi.mem_write) && mi.mem_waitrequest;
      hold_snap  = {mi.mem_read, mi.mem_write, mi.mem_address, mi.mem_writedata};

      if (mi.mem_write && !mi.mem_waitrequest) begin
        check(exp_q.size() != 0, "unexpected_write", 64'(mi.mem_address), 64'(0));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(mi.mem_address == e.addr && mi.mem_writedata == e.data, "write",
                {6'b0, mi.mem_address, mi.mem_writedata}, {6'b0, e.addr, e.data});
        end
        fb[mi.mem_address] = mi.mem_writedata;
        last_wr_edge = cyc + 1;
      end

      if (fi.done_out) begin
        done_pulses++;
        check(exp_done && cyc == last_wr_edge + 1 && exp_q.size() == 0, "done_pulse",
              64'(cyc), 64'(last_wr_edge + 1));
        exp_done = 1'b0;
      end
    end
  end

  // Called at edge+1; returns at edge+1 after the accepting edge.
  task automatic push(input logic [ADDR_W-1:0] a, input logic [23:0] c,
                      input logic [31:0] d, input bit pass);
    int n = 0;
    logic [ADDR_W-1:0] a4;
    a4 = a + 26'd4;
    if (pass) begin
      exp_q.push_back('{addr: a,  data: {8'h00, c}});
      exp_q.push_back('{addr: a4, data: d});
      exp_passed++;
    end
    fi.frag_addr  = a;
    fi.frag_color = c;
    fi.frag_depth = d;
    fi.frag_valid = 1'b1;
    while (fi.frag_stall && n < 300) begin
      @(posedge clock); #1; n++;
    end
    check(n < 300, "push_timeout", 64'(n), 64'(300));
    @(posedge clock); #1;
    fi.frag_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock); #1; n++;
    end
    check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (3) begin @(posedge clock); #1; end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fi.frag_addr = '0; fi.frag_color = '0; fi.frag_depth = '0;
    fi.frag_valid = 1'b0; fi.done_in = 1'b0;
    mi.mem_readdata = '0; mi.mem_readdatavalid = 1'b0; mi.mem_waitrequest = 1'b0;

    // Reset state
    #22;
    check(fi.frag_stall == 1'b1, "rst_stall", 64'(fi.frag_stall), 64'(1));
    check(mi.mem_write  == 1'b0, "rst_write", 64'(mi.mem_write), 64'(0));
    check(mi.mem_read   == 1'b0, "rst_read",  64'(mi.mem_read), 64'(0));
    check(mi.mem_address == '0,  "rst_addr",  64'(mi.mem_address), 64'(0));
    check(fi.done_out   == 1'b0, "rst_done",  64'(fi.done_out), 64'(0));
    check(frag_passed   == 32'd0, "rst_passed", 64'(frag_passed), 64'(0));
    check(frag_killed   == 32'd0, "rst_killed", 64'(frag_killed), 64'(0));
    reset = 1'b1;
    #1;
    check(fi.frag_stall == 1'b0, "rel_stall", 64'(fi.frag_stall), 64'(0));
    @(posedge clock); #1;

`ifdef DEPTH_TEST_EN
    // Depth test: closer passes, equal fails, negative passes.
    fb[26'h104] = 32'h0005_0000;
    push(26'h100, 24'h112233, 32'h0002_0000, 1'b1);
    wait_idle();
    check(frag_passed == 32'd1, "dt_pass_cnt", 64'(frag_passed), 64'(1));
    fb[26'h104] = 32'h0005_0000;
    push(26'h100, 24'h445566, 32'h0005_0000, 1'b0);
    cycles(12);
    check(frag_killed == 32'd1, "dt_kill_cnt", 64'(frag_killed), 64'(1));
    push(26'h100, 24'h778899, 32'hFFFF_0000, 1'b1);
    wait_idle();
    check(frag_passed == 32'd2, "dt_neg_cnt", 64'(frag_passed), 64'(2));
`endif

    // Basic writes, including address wrap of addr+4.
    push(26'h200,     24'hABCDEF, 32'hFFFF_0000, 1'b1);
    push(26'h3FFFFFC, 24'h00FF00, 32'h1234_5678, 1'b1);
    wait_idle();
    check(frag_passed == 32'(exp_passed), "basic_cnt", 64'(frag_passed), 64'(exp_passed));

    // Waitrequest held for 10 cycles on the first request of a fragment.
    mi.mem_waitrequest = 1'b1;
    push(26'h300, 24'h010203, 32'h0000_0001, 1'b1);
    cycles(10);
    mi.mem_waitrequest = 1'b0;
    wait_idle();
    check(frag_passed == 32'(exp_passed), "wait_cnt", 64'(frag_passed), 64'(exp_passed));

    // Back-pressure: first fragment stuck in the FSM, four fill the FIFO.
    mi.mem_waitrequest = 1'b1;
    push(26'h400, 24'h000001, 32'h0000_0010, 1'b1);
    for (int i = 1; i <= 4; i++)
      push(26'h400 + 26'(i * 16), 24'(i + 1), 32'(16 + i), 1'b1);
    check(fi.frag_stall == 1'b1, "stall_full", 64'(fi.frag_stall), 64'(1));
    fork
      push(26'h450, 24'h000006, 32'h0000_0015, 1'b1);
      begin
        repeat (4) begin
          @(posedge clock); #1;
          check(fi.frag_stall == 1'b1, "stall_hold", 64'(fi.frag_stall), 64'(1));
        end
        mi.mem_waitrequest = 1'b0;
      end
    join
    wait_idle();
    check(frag_passed == 32'(exp_passed), "bp_cnt", 64'(frag_passed), 64'(exp_passed));

    // Done: three fragments, done_in high two cycles -> exactly one pulse.
    push(26'h500, 24'hA1A2A3, 32'h0000_0100, 1'b1);
    push(26'h510, 24'hB1B2B3, 32'h0000_0200, 1'b1);
    push(26'h520, 24'hC1C2C3, 32'h0000_0300, 1'b1);
    exp_done   = 1'b1;
    fi.done_in = 1'b1;
    cycles(2);
    fi.done_in = 1'b0;
    wait_idle();
    cycles(5);
    check(done_pulses == 1, "done_count", 64'(done_pulses), 64'(1));

    // Reset while a write is held by waitrequest.
    fi.frag_addr = 26'h600; fi.frag_color = 24'h0F0F0F; fi.frag_depth = 32'h42;
    fi.frag_valid = 1'b1;
    @(posedge clock); #1;
    fi.frag_valid = 1'b0;
    for (int n = 0; n < 20 && !mi.mem_write; n++) begin @(posedge clock); #1; end
    mi.mem_waitrequest = 1'b1;
    cycles(2);
    check(mi.mem_write == 1'b1, "pre_rst_write", 64'(mi.mem_write), 64'(1));
    exp_q.delete();
    reset = 1'b0;
    #1;
    check(mi.mem_write     == 1'b0, "mid_rst_write", 64'(mi.mem_write), 64'(0));
    check(mi.mem_address   == '0,   "mid_rst_addr",  64'(mi.mem_address), 64'(0));
    check(mi.mem_writedata == '0,   "mid_rst_wdata", 64'(mi.mem_writedata), 64'(0));
    check(fi.frag_stall    == 1'b1, "mid_rst_stall", 64'(fi.frag_stall), 64'(1));
    check(frag_passed      == 32'd0, "mid_rst_passed", 64'(frag_passed), 64'(0));
    mi.mem_waitrequest = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check(fi.frag_stall == 1'b0, "post_rst_stall", 64'(fi.frag_stall), 64'(0));
    @(posedge clock); #1;
    exp_passed = 0;
    push(26'h700, 24'h123456, 32'h0000_0077, 1'b1);
    wait_idle();
    check(frag_passed == 32'd1, "post_rst_passed", 64'(frag_passed), 64'(1));
    check(frag_killed == 32'd0, "post_rst_killed", 64'(frag_killed), 64'(0));
    check(!both_seen, "read_write_excl", 64'(both_seen), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
